// File: rtl/ppu_vram_arbiter_if.sv
// Bus bundle between the PPU requesters, the VRAM arbiter and the external VRAM port.
// The arbiter connects through the slave modport; the requester/VRAM side uses master.
interface ppu_vram_arbiter_if;
    logic        render_req;
    logic [13:0] render_addr;
    logic        render_ack;
    logic        render_valid;
    logic [7:0]  render_data;

    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;

    logic [13:0] vram_a;
    logic        vram_r;
    logic        vram_w;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din;

    modport master (
        output render_req, render_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_din,
        input  render_ack, render_valid, render_data, cpu_busy, cpu_done, cpu_rdata,
        input  vram_a, vram_r, vram_w, vram_dout
    );

    modport slave (
        input  render_req, render_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_din,
        output render_ack, render_valid, render_data, cpu_busy, cpu_done, cpu_rdata,
        output vram_a, vram_r, vram_w, vram_dout
    );
endinterface

// File: rtl/ppu_vram_arbiter.sv
// Two-phase VRAM arbiter: render fetches have priority, CPU accesses wait in a one-entry latch.
// Define PPU_ARB_STARVE_GUARD_EN to force a starved CPU access ahead after STARVE_MAX ticks.
module ppu_vram_arbiter #(
    parameter int STARVE_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    ppu_vram_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic OWN_RENDER = 1'b0;
    localparam logic OWN_CPU    = 1'b1;

    logic [1:0]  state;
    logic        owner;
    logic        cur_we;
    logic        pend_valid;
    logic        busy;
    logic        pend_we;
    logic [13:0] pend_addr;
    logic [7:0]  pend_wdata;
    logic [13:0] addr_q;
    logic [7:0]  dout_q;
    logic [7:0]  render_data_q;
    logic [7:0]  cpu_rdata_q;
    logic        render_valid_q;
    logic        cpu_done_q;
    logic        grant_slot;
    logic        force_cpu;
    logic        grant_cpu;
    logic        grant_render;

    // pend_valid means "waiting for a grant"; busy stays up until the done pulse.
    assign grant_slot   = (state == ST_IDLE) || (state == ST_DATA);
    assign grant_cpu    = grant_slot && pend_valid && (force_cpu || !bus.render_req);
    assign grant_render = grant_slot && bus.render_req && !force_cpu;

`ifdef PPU_ARB_STARVE_GUARD_EN
    localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

    logic [4:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 5'd0;
        end else if (ce) begin
            if (grant_cpu) begin
                starve_cnt <= 5'd0;
            end else if (pend_valid && (starve_cnt != 5'd31)) begin
                starve_cnt <= starve_cnt + 5'd1;
            end
        end
    end

    assign force_cpu = pend_valid && (starve_cnt >= STARVE_LIM);
`else
    localparam logic [4:0] starve_lim_unused = 5'(STARVE_MAX);

    assign force_cpu = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            owner          <= OWN_RENDER;
            cur_we         <= 1'b0;
            pend_valid     <= 1'b0;
            busy           <= 1'b0;
            pend_we        <= 1'b0;
            pend_addr      <= 14'd0;
            pend_wdata     <= 8'd0;
            addr_q         <= 14'd0;
            dout_q         <= 8'd0;
            render_data_q  <= 8'd0;
            cpu_rdata_q    <= 8'd0;
            render_valid_q <= 1'b0;
            cpu_done_q     <= 1'b0;
        end else if (ce) begin
            render_valid_q <= 1'b0;
            cpu_done_q     <= 1'b0;

            if (cpu_done_q) begin
                busy <= 1'b0;
            end
            if (bus.cpu_req && !busy) begin
                pend_valid <= 1'b1;
                busy       <= 1'b1;
                pend_we    <= bus.cpu_we;
                pend_addr  <= bus.cpu_addr;
                pend_wdata <= bus.cpu_wdata;
            end

            if (state == ST_DATA) begin
                if (owner == OWN_RENDER) begin
                    render_data_q  <= bus.vram_din;
                    render_valid_q <= 1'b1;
                end else begin
                    if (!cur_we) begin
                        cpu_rdata_q <= bus.vram_din;
                    end
                    cpu_done_q <= 1'b1;
                end
            end

            // A grant on the tick leaving DATA gives back-to-back accesses.
            if (state == ST_ADDR) begin
                state <= ST_DATA;
            end else if (grant_cpu) begin
                state      <= ST_ADDR;
                owner      <= OWN_CPU;
                cur_we     <= pend_we;
                addr_q     <= pend_addr;
                dout_q     <= pend_wdata;
                pend_valid <= 1'b0;
            end else if (grant_render) begin
                state  <= ST_ADDR;
                owner  <= OWN_RENDER;
                cur_we <= 1'b0;
                addr_q <= bus.render_addr;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.render_ack   = (state == ST_ADDR) && (owner == OWN_RENDER);
    assign bus.vram_r       = (state == ST_ADDR) && !cur_we;
    assign bus.vram_w       = (state == ST_ADDR) && cur_we;
    assign bus.vram_a       = addr_q;
    assign bus.vram_dout    = dout_q;
    assign bus.render_valid = render_valid_q;
    assign bus.render_data  = render_data_q;
    assign bus.cpu_busy     = busy;
    assign bus.cpu_done     = cpu_done_q;
    assign bus.cpu_rdata    = cpu_rdata_q;

endmodule
